// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gcd_pkg
// Description : Shared state encoding and default sizing for the GCD requester.
// Revision    : 1.0 - initial release
// ============================================================================
package gcd_pkg;

   localparam int GCD_W_DEF       = 8;
   localparam int GCD_TIMEOUT_DEF = 1023;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_HOLD   = 2'd3
   } gcd_state_e;

endpackage
`default_nettype wire

// File: rtl/gcd_wdog.sv
`default_nettype none
// ============================================================================
// Module      : gcd_wdog
// Description : Counts enabled cycles; flags expiry on the TIMEOUT-th one.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_wdog
   import gcd_pkg::*;
#(
   parameter int TIMEOUT = GCD_TIMEOUT_DEF,
   parameter int CW      = $clog2(TIMEOUT + 1)
) (
   input  logic CLK,
   input  logic RESET,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [CW-1:0] c_LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          w_at_last;

   assign w_at_last = (cnt_q == c_LAST);

   // Expiry is reported during the last allowed cycle so the owner leaves on
   // the same edge that would otherwise complete the TIMEOUT-th cycle.
   assign expired_o = en_i & ~clr_i & w_at_last;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !w_at_last) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/gcd_requester.sv
`default_nettype none
// ============================================================================
// Module      : gcd_requester
// Description : Issues one operand pair at a time to a GCD unit, short-circuits
//               zero operands and guards the wait with a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_requester
   import gcd_pkg::*;
#(
   parameter int W       = GCD_W_DEF,
   parameter int TIMEOUT = GCD_TIMEOUT_DEF
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         gcd_go,
   output logic [W-1:0] gcd_x,
   output logic [W-1:0] gcd_y,
   input  logic         gcd_done,
   input  logic [W-1:0] gcd_d,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_d,
   output logic         out_err
);

   gcd_state_e   state_q, state_d;
   logic [W-1:0] x_q, x_d;
   logic [W-1:0] y_q, y_d;
   logic [W-1:0] res_q, res_d;
   logic         err_q, err_d;
   logic         go_q, go_d;
   logic         valid_q, valid_d;
   logic         rdy_q, rdy_d;

   logic         w_in_fire;
   logic         w_in_wait;
   logic         w_expired;

   assign w_in_fire = in_valid & rdy_q;
   assign w_in_wait = (state_q == S_WAIT);

   gcd_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .CLK       (CLK),
      .RESET     (RESET),
      .clr_i     (~w_in_wait),
      .en_i      (w_in_wait),
      .expired_o (w_expired)
   );

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      res_d   = res_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (w_in_fire) begin
               if ((in_a != '0) && (in_b != '0)) begin
                  x_d     = in_a;
                  y_d     = in_b;
                  state_d = S_LAUNCH;
               end else begin
                  // gcd(0,b)=b and gcd(a,0)=a; both zero falls out as 0.
                  res_d   = (in_a == '0) ? in_b : in_a;
                  err_d   = 1'b0;
                  state_d = S_HOLD;
               end
            end
         end
         S_LAUNCH: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (gcd_done) begin
               res_d   = gcd_d;
               err_d   = 1'b0;
               state_d = S_HOLD;
            end else if (w_expired) begin
               res_d   = '0;
               err_d   = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Handshake outputs are registered copies of the next state.
      go_d    = (state_d == S_LAUNCH);
      valid_d = (state_d == S_HOLD);
      rdy_d   = (state_d == S_IDLE);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         go_q    <= 1'b0;
         valid_q <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         res_q   <= res_d;
         err_q   <= err_d;
         go_q    <= go_d;
         valid_q <= valid_d;
         rdy_q   <= rdy_d;
      end
   end

   assign in_ready  = rdy_q;
   assign gcd_go    = go_q;
   assign gcd_x     = x_q;
   assign gcd_y     = y_q;
   assign out_valid = valid_q;
   assign out_d     = res_q;
   assign out_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gcd_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcd_requester
// Description : Directed scoreboard bench for gcd_requester with a GCD model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_requester;

   localparam int W  = 8;
   localparam int TO = 1023;

   logic         CLK = 1'b0;
   logic         RESET = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         out_ready = 1'b1;
   logic         in_ready, gcd_go, gcd_done, out_valid, out_err;
   logic [W-1:0] gcd_x, gcd_y, gcd_d, out_d;

   logic         model_done = 1'b0;
   logic [W-1:0] model_d = '0;
   logic         stray_done = 1'b0;
   logic [W-1:0] stray_d = '0;

   assign gcd_done = model_done | stray_done;
   assign gcd_d    = stray_done ? stray_d : model_d;

   gcd_requester #(.W(W), .TIMEOUT(TO)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .gcd_go    (gcd_go),
      .gcd_x     (gcd_x),
      .gcd_y     (gcd_y),
      .gcd_done  (gcd_done),
      .gcd_d     (gcd_d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_d     (out_d),
      .out_err   (out_err)
   );

   initial forever #5 CLK = ~CLK;

   typedef struct packed {
      logic [W-1:0] d;
      logic         err;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   go_cnt      = 0;
   bit   model_en    = 1'b1;
   int   model_lat   = 3;

   function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a0, input logic [W-1:0] b0);
      logic [W-1:0] a, b, t;
      a = a0;
      b = b0;
      while (b != '0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // GCD unit model: answers each go after model_lat edges with a one-cycle done.
   initial forever begin
      logic [W-1:0] r;
      @(negedge CLK);
      if (gcd_go) begin
         go_cnt++;
         if (model_en && !RESET) begin
            r = gcd_ref(gcd_x, gcd_y);
            repeat (model_lat) @(posedge CLK);
            #1;
            model_done = 1'b1;
            model_d    = r;
            @(posedge CLK);
            #1;
            model_done = 1'b0;
         end
      end
   end

   // Monitor: every accepted result must match the oldest expectation.
   initial forever begin
      exp_t e;
      @(negedge CLK);
      if (!RESET && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_out: got out_d=%0d out_err=%0d, expected no result", out_d, out_err);
         end else begin
            e = sb.pop_front();
            check("out_d", {24'd0, out_d}, {24'd0, e.d});
            check("out_err", {31'd0, out_err}, {31'd0, e.err});
         end
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                       input logic [W-1:0] ed, input logic ee);
      int n;
      exp_t e;
      n = 0;
      while (!in_ready && n < 3000) begin
         tick();
         n++;
      end
      if (!in_ready) check("send_wait_in_ready", {31'd0, in_ready}, 32'd1);
      if (push) begin
         e.d   = ed;
         e.err = ee;
         sb.push_back(e);
      end
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 3000) begin
         tick();
         n++;
      end
      check("drain_queue_empty", sb.size(), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
      check({tag, "_gcd_go"},    {31'd0, gcd_go},    32'd0);
      check({tag, "_gcd_x"},     {24'd0, gcd_x},     32'd0);
      check({tag, "_gcd_y"},     {24'd0, gcd_y},     32'd0);
      check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_out_d"},     {24'd0, out_d},     32'd0);
      check({tag, "_out_err"},   {31'd0, out_err},   32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int go0, k, seen;

      // Reset state and first ready cycle
      repeat (3) tick();
      check_all_zero("reset");
      RESET = 1'b0;
      tick();
      check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

      // 48,18 -> 6 through the GCD unit, one go pulse, stable operands
      go0 = go_cnt;
      send(8'd48, 8'd18, 1'b1, 8'd6, 1'b0);
      check("go_latency", {31'd0, gcd_go}, 32'd1);
      tick();
      check("gcd_go_one_cycle", {31'd0, gcd_go}, 32'd0);
      check("gcd_x_stable", {24'd0, gcd_x}, 32'd48);
      check("gcd_y_stable", {24'd0, gcd_y}, 32'd18);
      drain();
      check("go_pulses_48_18", go_cnt - go0, 32'd1);

      // Zero short-circuits: no go, result in the next cycle
      go0 = go_cnt;
      send(8'd0, 8'd7, 1'b1, 8'd7, 1'b0);
      check("short_latency", {31'd0, out_valid}, 32'd1);
      drain();
      send(8'd0, 8'd0, 1'b1, 8'd0, 1'b0);
      drain();
      send(8'd9, 8'd0, 1'b1, 8'd9, 1'b0);
      drain();
      check("short_no_go", go_cnt - go0, 32'd0);

      // Back-pressure in HOLD
      out_ready = 1'b0;
      send(8'd48, 8'd18, 1'b1, 8'd6, 1'b0);
      k = 0;
      while (!out_valid && k < 100) begin
         tick();
         k++;
      end
      check("hold_reached", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_out_d", {24'd0, out_d}, 32'd6);
         check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      tick();
      check("in_ready_after_release", {31'd0, in_ready}, 32'd1);
      check("valid_after_release", {31'd0, out_valid}, 32'd0);

      // Done arriving in the last watchdog cycle wins over the timeout
      model_lat = TO;
      send(8'd20, 8'd15, 1'b1, 8'd5, 1'b0);
      drain();
      model_lat = 3;

      // Silent GCD unit: timeout after TO WAIT cycles
      model_en = 1'b0;
      send(8'd12, 8'd8, 1'b1, 8'd0, 1'b1);
      k = 0;
      while (!out_valid && k < TO + 50) begin
         tick();
         k++;
      end
      check("timeout_wait_cycles", k - 1, TO);
      drain();

      // Reset during WAIT abandons the job; a late done is ignored
      send(8'd30, 8'd12, 1'b0, 8'd0, 1'b0);
      repeat (10) tick();
      RESET = 1'b1;
      #1;
      check_all_zero("rst_wait");
      repeat (2) tick();
      RESET = 1'b0;
      tick();
      stray_done = 1'b1;
      stray_d    = 8'd99;
      tick();
      stray_done = 1'b0;
      seen = 0;
      repeat (20) begin
         tick();
         if (out_valid) seen++;
      end
      check("no_out_after_reset", seen, 32'd0);
      model_en = 1'b1;

      // Stray done in IDLE, then 35,21 -> 7
      stray_done = 1'b1;
      stray_d    = 8'd55;
      tick();
      stray_done = 1'b0;
      seen = 0;
      repeat (5) begin
         tick();
         if (out_valid) seen++;
      end
      check("no_out_stray_idle", seen, 32'd0);
      send(8'd35, 8'd21, 1'b1, 8'd7, 1'b0);
      drain();

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
